// File: rtl/d_stage_rf_pipe_if.sv
// Decode-stage bundle: D-side operands, writeback port,
// E-side control and the registered/forwarded results.
interface d_stage_rf_pipe_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NFWD = 3
);
  localparam int SW = $clog2(NFWD + 1);

  logic              ValidD;
  logic [DW-1:0]     IRD;
  logic [DW-1:0]     PC8D;
  logic [NRD*AW-1:0] RA;
  logic [NRD*SW-1:0] FwdSel;
  logic [NFWD*DW-1:0] FwdData;
  logic              We;
  logic [AW-1:0]     A3;
  logic [DW-1:0]     WD;
  logic              StallE;
  logic              FlushE;
  logic [NRD*DW-1:0] RDD;
  logic              ValidE;
  logic [DW-1:0]     IRE;
  logic [DW-1:0]     PC8E;
  logic [NRD*DW-1:0] RDE;

  modport master (
    output ValidD, IRD, PC8D, RA, FwdSel, FwdData,
    output We, A3, WD, StallE, FlushE,
    input  RDD, ValidE, IRE, PC8E, RDE
  );

  modport slave (
    input  ValidD, IRD, PC8D, RA, FwdSel, FwdData,
    input  We, A3, WD, StallE, FlushE,
    output RDD, ValidE, IRE, PC8E, RDE
  );
endinterface

// File: rtl/d_stage_rf_pipe.sv
// Decode stage: register file with bypass and forwarding,
// plus the D->E pipeline register with stall and flush.
module d_stage_rf_pipe #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NFWD = 3
) (
  input logic              Clk,
  input logic              Reset,
  d_stage_rf_pipe_if.slave bus
);
  localparam int SW    = $clog2(NFWD + 1);
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]     rf_q [DEPTH];
  logic [DW-1:0]     rf_d [DEPTH];
  logic [NRD*DW-1:0] rdd;

  logic              valid_e_q, valid_e_d;
  logic [DW-1:0]     ire_q, ire_d;
  logic [DW-1:0]     pc8e_q, pc8e_d;
  logic [NRD*DW-1:0] rde_q, rde_d;

  always_comb begin
    rf_d = rf_q;
    if (bus.We && bus.A3 != '0)
      rf_d[bus.A3] = bus.WD;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++)
        rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Later assignments override earlier ones: r0 > fwd > bypass > rf.
  always_comb begin
    logic [AW-1:0] ra;
    logic [SW-1:0] sel;
    logic [DW-1:0] val;
    rdd = '0;
    ra  = '0;
    sel = '0;
    val = '0;
    for (int i = 0; i < NRD; i++) begin
      ra  = bus.RA[i*AW +: AW];
      sel = bus.FwdSel[i*SW +: SW];
      val = rf_q[ra];
      if (bus.We && bus.A3 == ra)
        val = bus.WD;
      for (int k = 1; k <= NFWD; k++)
        if (int'(sel) == k)
          val = bus.FwdData[(k-1)*DW +: DW];
      if (ra == '0)
        val = '0;
      rdd[i*DW +: DW] = val;
    end
  end

  assign bus.RDD = rdd;

  always_comb begin
    valid_e_d = valid_e_q;
    ire_d     = ire_q;
    pc8e_d    = pc8e_q;
    rde_d     = rde_q;
    if (bus.FlushE) begin
      valid_e_d = 1'b0;
      ire_d     = '0;
      pc8e_d    = '0;
      rde_d     = '0;
    end else if (!bus.StallE) begin
      valid_e_d = bus.ValidD;
      ire_d     = bus.IRD;
      pc8e_d    = bus.PC8D;
      rde_d     = rdd;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_e_q <= 1'b0;
      ire_q     <= '0;
      pc8e_q    <= '0;
      rde_q     <= '0;
    end else begin
      valid_e_q <= valid_e_d;
      ire_q     <= ire_d;
      pc8e_q    <= pc8e_d;
      rde_q     <= rde_d;
    end
  end

  assign bus.ValidE = valid_e_q;
  assign bus.IRE    = ire_q;
  assign bus.PC8E   = pc8e_q;
  assign bus.RDE    = rde_q;
endmodule
